// File: rtl/axi_read_responder_if.sv
// Purpose: AR/R channel bundle between a burst read initiator and responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both AR (arvalid/arready) and R (rvalid/rready).
//
// Signals:
//   araddr  [31:0] byte address of first beat      (master -> slave)
//   arlen   [3:0]  beats minus one                 (master -> slave)
//   arvalid        address valid                   (master -> slave)
//   arready        address ready                   (slave  -> master)
//   rdata   [31:0] read data                       (slave  -> master)
//   rlast          final beat of burst             (slave  -> master)
//   rvalid         data valid                      (slave  -> master)
//   rready         master ready for data           (master -> slave)
interface axi_read_responder_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_read_responder.sv
// Purpose: single-outstanding INCR burst read responder backed by a preloadable word memory.
// Latency: address handshake at edge T -> first rvalid in cycle T+2+LATENCY, then one beat per rvalid&rready.
// Backpressure: rready low holds rdata/rlast/rvalid; arready low until the last beat is accepted.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bus (slave modport)   AR/R channel: araddr/arlen/arvalid/arready, rdata/rlast/rvalid/rready
//   init_we/addr/data     side preload port, writes mem[init_addr] in any state (also during reset)
module axi_read_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  axi_read_responder_if.slave bus,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [31:0]       init_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_BURST
  } state_t;

  // Wait counter start value; counts LATENCY-1 down to 0 so WAIT lasts LATENCY cycles.
  localparam logic [3:0] WCNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [MEM_AW-1:0] ptr_inc;
  logic [3:0]        len_q, len_d;
  logic [3:0]        beat_q, beat_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rlast_q, rlast_d;
  logic              rvalid_q, rvalid_d;

  // Word memory; contents survive reset on purpose so a bench can preload once.
  logic [31:0] mem_q [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_addr] <= init_data;
    end
  end

  // Pointer wraps naturally at MEM_AW bits.
  assign ptr_inc = ptr_q + MEM_AW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    rdata_d  = rdata_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;

    case (state_q)
      S_IDLE: begin
        // arready is high in IDLE whenever reset is not asserted, and reset
        // overrides this path in the register block, so arvalid alone suffices.
        if (bus.arvalid) begin
          ptr_d  = bus.araddr[MEM_AW+1:2];
          len_d  = bus.arlen;
          beat_d = 4'd0;
          if (LATENCY == 0) begin
            state_d = S_LOAD;
          end else begin
            wcnt_d  = WCNT_INIT;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = S_LOAD;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end

      S_LOAD: begin
        rdata_d  = mem_q[ptr_q];
        rlast_d  = (len_q == 4'd0);
        rvalid_d = 1'b1;
        state_d  = S_BURST;
      end

      S_BURST: begin
        if (rvalid_q && bus.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            // Next word is fetched on the same edge that retires the current
            // beat, so a stalled beat never re-reads memory.
            ptr_d   = ptr_inc;
            beat_d  = beat_q + 4'd1;
            rdata_d = mem_q[ptr_inc];
            rlast_d = ((beat_q + 4'd1) == len_q);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= 4'd0;
      beat_q   <= 4'd0;
      wcnt_q   <= 4'd0;
      rdata_q  <= 32'h0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      wcnt_q   <= wcnt_d;
      rdata_q  <= rdata_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.arready = (state_q == S_IDLE) & ~rst;
  assign bus.rdata   = rdata_q;
  assign bus.rlast   = rlast_q;
  assign bus.rvalid  = rvalid_q;

  // Byte-lane bits and address bits above the memory are deliberately ignored.
  logic unused_araddr_bits;
  assign unused_araddr_bits = ^{bus.araddr[31:MEM_AW+2], bus.araddr[1:0]};

endmodule

// File: tb/tb_axi_read_responder.sv
// Purpose: directed bench for axi_read_responder (main instance LATENCY=2, MEM_AW=12; second instance LATENCY=0, MEM_AW=4).
// Latency: checks first-beat timing against handshake cycle.
// Backpressure: drives rready stall patterns and checks held outputs.
module tb_axi_read_responder;
  localparam int LAT_M = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  axi_read_responder_if bm ();
  axi_read_responder_if bw ();

  logic        init_we_m, init_we_w;
  logic [11:0] init_addr_m;
  logic [3:0]  init_addr_w;
  logic [31:0] init_data_m, init_data_w;

  axi_read_responder #(.MEM_AW(12), .LATENCY(LAT_M)) dut (
    .clk(clk), .rst(rst), .bus(bm.slave),
    .init_we(init_we_m), .init_addr(init_addr_m), .init_data(init_data_m)
  );

  axi_read_responder #(.MEM_AW(4), .LATENCY(0)) dutw (
    .clk(clk), .rst(rst), .bus(bw.slave),
    .init_we(init_we_w), .init_addr(init_addr_w), .init_data(init_data_w)
  );

  logic [31:0] model_m [4096];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [15:0] stall;   // bit k set: rready low in k-th rvalid cycle
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic preload_m(input logic [11:0] a, input logic [31:0] d);
    init_we_m = 1'b1; init_addr_m = a; init_data_m = d; model_m[a] = d;
    @(negedge clk);
    init_we_m = 1'b0;
  endtask

  task automatic preload_w(input logic [3:0] a, input logic [31:0] d);
    init_we_w = 1'b1; init_addr_w = a; init_data_w = d;
    @(negedge clk);
    init_we_w = 1'b0;
  endtask

  // Entered just after a negedge; returns just after a negedge.
  task automatic do_burst(input string name, input logic [31:0] addr, input logic [3:0] len,
                          input logic [15:0] stall, input logic [31:0] exp_first,
                          input logic [31:0] exp_last);
    int hs, waitc, beats, k;
    logic [11:0] w;
    logic [31:0] held_d;
    logic held_l, prev_stall, rr;
    bm.araddr = addr; bm.arlen = len; bm.arvalid = 1'b1; bm.rready = 1'b0;
    waitc = 0;
    while (bm.arready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (bm.arready !== 1'b1) begin tmo({name, "_ar"}); bm.arvalid = 1'b0; return; end
    hs = cyc + 1;
    @(negedge clk);
    bm.arvalid = 1'b0;
    waitc = 0;
    while (bm.rvalid !== 1'b1 && waitc < 50) begin
      chk({name, "_arready_busy"}, 32'(bm.arready), 32'd0);
      @(negedge clk); waitc++;
    end
    if (bm.rvalid !== 1'b1) begin tmo({name, "_rvalid"}); return; end
    chk({name, "_latency"}, 32'(cyc + 1 - hs), 32'(2 + LAT_M));
    beats = 0; k = 0; prev_stall = 1'b0; held_d = '0; held_l = 1'b0;
    while (beats <= int'(len) && k < 64) begin
      chk({name, "_rvalid"}, 32'(bm.rvalid), 32'd1);
      chk({name, "_arready_burst"}, 32'(bm.arready), 32'd0);
      if (prev_stall) begin
        chk({name, "_hold_rdata"}, bm.rdata, held_d);
        chk({name, "_hold_rlast"}, 32'(bm.rlast), 32'(held_l));
      end
      w = addr[13:2] + 12'(beats);
      chk($sformatf("%s_beat%0d", name, beats), bm.rdata, model_m[w]);
      chk($sformatf("%s_rlast%0d", name, beats), 32'(bm.rlast), 32'(beats == int'(len)));
      if (beats == 0) chk({name, "_first"}, bm.rdata, exp_first);
      if (beats == int'(len)) chk({name, "_last"}, bm.rdata, exp_last);
      rr = ~stall[k[3:0]];
      bm.rready = rr;
      held_d = bm.rdata; held_l = bm.rlast; prev_stall = ~rr;
      if (rr) beats++;
      k++;
      @(negedge clk);
    end
    if (k >= 64) tmo({name, "_beats"});
    bm.rready = 1'b0;
    chk({name, "_end_rvalid"}, 32'(bm.rvalid), 32'd0);
    chk({name, "_end_rlast"}, 32'(bm.rlast), 32'd0);
    chk({name, "_end_arready"}, 32'(bm.arready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, e, waitc;
    logic [31:0] wexp [4];
    bm.araddr = '0; bm.arlen = '0; bm.arvalid = 1'b0; bm.rready = 1'b0;
    bw.araddr = '0; bw.arlen = '0; bw.arvalid = 1'b0; bw.rready = 1'b0;
    init_we_m = 1'b0; init_addr_m = '0; init_data_m = '0;
    init_we_w = 1'b0; init_addr_w = '0; init_data_w = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(bm.arready), 32'd0);
    chk("rst_rvalid", 32'(bm.rvalid), 32'd0);
    chk("rst_rlast", 32'(bm.rlast), 32'd0);
    chk("rst_rdata", bm.rdata, 32'h0);
    chk("rst_w_arready", 32'(bw.arready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_arready", 32'(bm.arready), 32'd1);
    chk("rel_w_arready", 32'(bw.arready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 128; i++) preload_m(12'(i), 32'(i));
    preload_m(12'd5, 32'hDEADBEEF);
    preload_m(12'd4095, 32'hCAFE0FFF);

    // Table-driven bursts on the LATENCY=2 instance
    vecs[0] = '{addr: 32'h0000_0014, len: 4'd0,  stall: 16'h0000, first: 32'hDEADBEEF, last: 32'hDEADBEEF};
    vecs[1] = '{addr: 32'h0000_0020, len: 4'd7,  stall: 16'h0000, first: 32'd8,  last: 32'd15};
    vecs[2] = '{addr: 32'h0000_0020, len: 4'd7,  stall: 16'h6666, first: 32'd8,  last: 32'd15};
    vecs[3] = '{addr: 32'h0000_3FFC, len: 4'd2,  stall: 16'h0000, first: 32'hCAFE0FFF, last: 32'd1};
    vecs[4] = '{addr: 32'hFFFF_0103, len: 4'd15, stall: 16'h8001, first: 32'd64, last: 32'd79};
    for (int i = 0; i < 5; i++) begin
      do_burst($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].stall,
               vecs[i].first, vecs[i].last);
    end

    // Back-to-back: arvalid held high across two requests
    bm.araddr = 32'h20; bm.arlen = 4'd1; bm.arvalid = 1'b1; bm.rready = 1'b1;
    waitc = 0;
    while (bm.arready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (bm.arready !== 1'b1) tmo("b2b_ar1");
    @(negedge clk);
    bm.araddr = 32'h14; bm.arlen = 4'd0;
    waitc = 0;
    while (!(bm.rvalid === 1'b1 && bm.rlast === 1'b1) && waitc < 50) begin
      chk("b2b_arready_low", 32'(bm.arready), 32'd0);
      @(negedge clk); waitc++;
    end
    if (bm.rlast !== 1'b1) tmo("b2b_last");
    chk("b2b_last_data", bm.rdata, 32'd9);
    e = cyc + 1;
    @(negedge clk);
    chk("b2b_arready_next", 32'(bm.arready), 32'd1);
    hs = cyc + 1;
    chk("b2b_gap", 32'(hs - e), 32'd1);
    @(negedge clk);
    bm.arvalid = 1'b0;
    waitc = 0;
    while (bm.rvalid !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (bm.rvalid !== 1'b1) tmo("b2b_r2");
    chk("b2b_latency2", 32'(cyc + 1 - hs), 32'(2 + LAT_M));
    chk("b2b_data2", bm.rdata, 32'hDEADBEEF);
    chk("b2b_rlast2", 32'(bm.rlast), 32'd1);
    @(negedge clk);
    chk("b2b_end", 32'(bm.rvalid), 32'd0);
    bm.rready = 1'b0;

    // Reset mid-burst after two beats accepted
    bm.araddr = 32'h20; bm.arlen = 4'd7; bm.arvalid = 1'b1; bm.rready = 1'b1;
    waitc = 0;
    while (bm.arready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    @(negedge clk);
    bm.arvalid = 1'b0;
    waitc = 0;
    while (!(bm.rvalid === 1'b1 && bm.rdata === 32'd10) && waitc < 50) begin @(negedge clk); waitc++; end
    if (bm.rdata !== 32'd10) tmo("rstmid_beat2");
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_rvalid", 32'(bm.rvalid), 32'd0);
    chk("rstmid_rlast", 32'(bm.rlast), 32'd0);
    chk("rstmid_rdata", bm.rdata, 32'h0);
    chk("rstmid_arready", 32'(bm.arready), 32'd0);
    rst = 1'b0;
    bm.rready = 1'b0;
    #1;
    chk("rstmid_arready_rel", 32'(bm.arready), 32'd1);
    @(negedge clk);
    chk("rstmid_dropped", 32'(bm.rvalid), 32'd0);
    do_burst("rstmid_new", 32'h14, 4'd0, 16'h0, 32'hDEADBEEF, 32'hDEADBEEF);

    // Preload during a stalled burst: latched word unaffected, pending word updated
    bm.araddr = 32'h20; bm.arlen = 4'd2; bm.arvalid = 1'b1; bm.rready = 1'b0;
    waitc = 0;
    while (bm.arready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    @(negedge clk);
    bm.arvalid = 1'b0;
    waitc = 0;
    while (bm.rvalid !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (bm.rvalid !== 1'b1) tmo("pl_rvalid");
    chk("pl_first", bm.rdata, 32'd8);
    preload_m(12'd8, 32'h1111_1111);
    preload_m(12'd10, 32'h2222_2222);
    chk("pl_latched_hold", bm.rdata, 32'd8);
    bm.rready = 1'b1;
    wexp[0] = 32'd8; wexp[1] = 32'd9; wexp[2] = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pl_beat%0d", i), bm.rdata, wexp[i]);
      chk($sformatf("pl_rlast%0d", i), 32'(bm.rlast), 32'(i == 2));
      @(negedge clk);
    end
    chk("pl_end", 32'(bm.rvalid), 32'd0);
    bm.rready = 1'b0;
    preload_m(12'd8, 32'd8);
    preload_m(12'd10, 32'd10);

    // Wrap on MEM_AW=4, LATENCY=0 instance
    preload_w(4'd14, 32'hA000_000A);
    preload_w(4'd15, 32'hB000_000B);
    preload_w(4'd0,  32'hC000_000C);
    preload_w(4'd1,  32'hD000_000D);
    wexp[0] = 32'hA000_000A; wexp[1] = 32'hB000_000B;
    wexp[2] = 32'hC000_000C; wexp[3] = 32'hD000_000D;
    bw.araddr = 32'h38; bw.arlen = 4'd3; bw.arvalid = 1'b1; bw.rready = 1'b1;
    waitc = 0;
    while (bw.arready !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    hs = cyc + 1;
    @(negedge clk);
    bw.arvalid = 1'b0;
    waitc = 0;
    while (bw.rvalid !== 1'b1 && waitc < 50) begin @(negedge clk); waitc++; end
    if (bw.rvalid !== 1'b1) tmo("wrap_rvalid");
    chk("wrap_latency", 32'(cyc + 1 - hs), 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_beat%0d", i), bw.rdata, wexp[i]);
      chk($sformatf("wrap_rvalid%0d", i), 32'(bw.rvalid), 32'd1);
      chk($sformatf("wrap_rlast%0d", i), 32'(bw.rlast), 32'(i == 3));
      @(negedge clk);
    end
    chk("wrap_end", 32'(bw.rvalid), 32'd0);
    chk("wrap_arready", 32'(bw.arready), 32'd1);
    bw.rready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
